// File: rtl/alu_pkg.sv
// Opcode encodings and opcode-class helpers shared by the ALU core and its pipeline wrapper.
// Codes 0-7 keep the legacy 8-bit ALU numbering so existing microcode stays valid.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_INC = 4'h6;
  localparam logic [3:0] OP_DEC = 4'h7;
  localparam logic [3:0] OP_ADC = 4'h8;
  localparam logic [3:0] OP_SBB = 4'h9;
  localparam logic [3:0] OP_SHL = 4'hA;
  localparam logic [3:0] OP_SHR = 4'hB;
  localparam logic [3:0] OP_ASR = 4'hC;
  localparam logic [3:0] OP_ROL = 4'hD;
  localparam logic [3:0] OP_ROR = 4'hE;
  localparam logic [3:0] OP_CMP = 4'hF;

  // Ops that go through the shared adder and report signed overflow.
  function automatic logic is_arith(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_ADC, OP_SBB, OP_CMP};
  endfunction

  // Bitwise ops are the only ones that leave the carry register alone.
  function automatic logic is_logic(input logic [3:0] op);
    return op inside {OP_AND, OP_OR, OP_XOR, OP_NOT};
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: one WIDTH+1-bit adder for the arithmetic class,
// bitwise ops, and a shifter/rotator whose amount is b modulo WIDTH.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  input  logic             cin,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             overflow
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW:0] WBITS = (SW+1)'(WIDTH);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [SW-1:0]    amt;
  logic [SW:0]      inv_amt;
  logic [WIDTH-1:0] add_b;
  logic             add_c;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   shr_w;
  logic [WIDTH:0]   asr_w;
  logic [WIDTH-1:0] rol;
  logic [WIDTH-1:0] ror;

  assign amt     = b[SW-1:0];
  assign inv_amt = WBITS - {1'b0, amt};

  // Subtraction is a + ~b + cin, so the adder's second operand and carry-in
  // are the only things that differ across the arithmetic class.
  always_comb begin
    add_b = b;
    add_c = 1'b0;
    case (opcode)
      OP_SUB, OP_CMP: begin add_b = ~b;   add_c = 1'b1; end
      OP_INC:         begin add_b = ONE;  add_c = 1'b0; end
      OP_DEC:         begin add_b = ~ONE; add_c = 1'b1; end
      OP_ADC:         begin add_b = b;    add_c = cin;  end
      OP_SBB:         begin add_b = ~b;   add_c = cin;  end
      default:        ;
    endcase
  end

  assign sum = {1'b0, a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_c};

  // The extra bit catches the last bit shifted out; amount 0 leaves it clear.
  assign shl_w = {1'b0, a} << amt;
  assign shr_w = {a, 1'b0} >> amt;
  assign asr_w = $signed({a, 1'b0}) >>> amt;
  assign rol   = (a << amt) | (a >> inv_amt);
  assign ror   = (a >> amt) | (a << inv_amt);

  always_comb begin
    res      = '0;
    cout     = 1'b0;
    overflow = 1'b0;
    if (is_arith(opcode)) begin
      res      = (opcode == OP_CMP) ? a : sum[WIDTH-1:0];
      cout     = sum[WIDTH];
      overflow = (a[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end else begin
      case (opcode)
        OP_AND: res = a & b;
        OP_OR:  res = a | b;
        OP_XOR: res = a ^ b;
        OP_NOT: res = ~a;
        OP_SHL: begin res = shl_w[WIDTH-1:0]; cout = shl_w[WIDTH]; end
        OP_SHR: begin res = shr_w[WIDTH:1];   cout = shr_w[0];     end
        OP_ASR: begin res = asr_w[WIDTH:1];   cout = asr_w[0];     end
        OP_ROL: begin res = rol; cout = (amt != '0) && rol[0];       end
        OP_ROR: begin res = ror; cout = (amt != '0) && ror[WIDTH-1]; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU stage between operand fetch and writeback: one output register
// with valid/ready on both sides, plus the carry register used by ADC/SBB.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  input  logic             carry_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             zero,
  output logic             sign,
  output logic             overflow,
  output logic             carry_q
);

  logic [WIDTH-1:0] core_res;
  logic             core_cout;
  logic             core_ovf;
  logic             accept;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a        (a),
    .b        (b),
    .opcode   (opcode),
    .cin      (carry_q),
    .res      (core_res),
    .cout     (core_cout),
    .overflow (core_ovf)
  );

  // Single output stage: a new op may enter only when the held result leaves.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // carry_clr only acts on idle cycles; an accepted op owns the carry register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      res       <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      sign      <= 1'b0;
      overflow  <= 1'b0;
      carry_q   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      res       <= core_res;
      cout      <= core_cout;
      zero      <= (core_res == '0);
      sign      <= core_res[WIDTH-1];
      overflow  <= core_ovf;
      if (!is_logic(opcode)) carry_q <= core_cout;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (carry_clr) carry_q <= 1'b0;
    end
  end

endmodule
